uart_rx_autobaud_ctrl: RTL and testbench



---
 rtl/uart_rx_autobaud_ctrl.sv | 144 ++++++++++++++
 tb/tb_uart_rx_autobaud_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_autobaud_ctrl.sv
// uart_rx_autobaud_ctrl: sweeps receiver baud candidates 7..0 until a repeated sync byte locks one, then forwards good bytes; define AUTOBAUD_RELOCK_EN to drop lock after ERR_LIMIT consecutive bad frames
module uart_rx_autobaud_ctrl #(
  parameter logic [7:0] SYNC_BYTE   = 8'h55,
  parameter int         MATCH_COUNT = 2,
  parameter int         TIMEOUT     = 5000000,
  parameter int         SETTLE_CYC  = 16,
  parameter int         MAX_PASSES  = 3,
  parameter int         ERR_LIMIT   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] Rx_DATA,
  input  logic       Rx_VALID,
  input  logic       Rx_FERROR,
  input  logic       Rx_PERROR,
  output logic [2:0] baud_select,
  output logic       Rx_EN,
  output logic       busy,
  output logic       locked,
  output logic       fail,
  output logic [7:0] data_out,
  output logic       data_valid
);
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_LISTEN, S_LOCKED, S_FAIL} state_t;
  state_t      r_state, w_state_nx;
  logic [2:0]  r_baud, w_baud_nx;
  logic [3:0]  r_pass, w_pass_nx, w_adv_pass;
  logic [3:0]  r_match, w_match_nx, w_match_inc;
  logic [31:0] r_cnt, w_cnt_nx;
  logic [7:0]  r_data;
  logic        r_dv, r_any_q;
  logic        w_any, w_event, w_good, w_sync, w_fwd;
  logic        w_wrap, w_adv_fail, w_timeout, w_restart, w_counting;
`ifdef AUTOBAUD_RELOCK_EN
  logic [7:0]  r_err, w_err_nx, w_err_inc;
  assign w_err_inc = r_err + 8'd1;
`else
  logic        w_unused_err;
  assign w_unused_err = (ERR_LIMIT == 0);
`endif
  assign w_any       = Rx_VALID | Rx_FERROR | Rx_PERROR;
  assign w_event     = w_any & ~r_any_q & Rx_EN;
  assign w_good      = w_event & Rx_VALID & ~Rx_FERROR & ~Rx_PERROR;
  assign w_sync      = w_good & (Rx_DATA == SYNC_BYTE);
  assign w_fwd       = (r_state == S_LOCKED) & w_good & ~abort;
  assign w_match_inc = r_match + 4'd1;
  assign w_wrap      = (r_baud == 3'd0);
  assign w_adv_pass  = w_wrap ? r_pass + 4'd1 : r_pass;
  assign w_adv_fail  = w_wrap && (w_adv_pass == 4'(MAX_PASSES));
  assign w_timeout   = (r_cnt >= 32'(TIMEOUT - 1));
  assign w_counting  = (r_state == S_SETTLE) || (r_state == S_LISTEN);
  assign w_restart   = start && (r_state == S_IDLE || r_state == S_LOCKED || r_state == S_FAIL);
  assign baud_select = r_baud;
  assign Rx_EN       = (r_state == S_LISTEN) || (r_state == S_LOCKED);
  assign busy        = w_counting;
  assign locked      = (r_state == S_LOCKED);
  assign fail        = (r_state == S_FAIL);
  assign data_out    = r_data;
  assign data_valid  = r_dv;
  // next state and counters: abort beats start, a sync match beats the timeout
  always_comb begin
    w_state_nx = r_state;
    w_baud_nx  = r_baud;
    w_pass_nx  = r_pass;
    w_cnt_nx   = w_counting ? r_cnt + 32'd1 : 32'd0;
    w_match_nx = r_match;
`ifdef AUTOBAUD_RELOCK_EN
    w_err_nx   = (r_state == S_LOCKED) ? r_err : 8'd0;
`endif
    if (abort) begin
      w_state_nx = S_IDLE;
    end else if (w_restart) begin
      w_state_nx = S_SETTLE;
      w_baud_nx  = 3'd7;
      w_pass_nx  = 4'd0;
      w_cnt_nx   = 32'd0;
    end else if (r_state == S_SETTLE) begin
      w_match_nx = 4'd0;
      if (r_cnt == 32'(SETTLE_CYC - 1)) begin
        w_state_nx = S_LISTEN;
        w_cnt_nx   = 32'd0;
      end
    end else if (r_state == S_LISTEN) begin
      if (w_sync) begin
        w_match_nx = w_match_inc;
        if (w_match_inc == 4'(MATCH_COUNT)) w_state_nx = S_LOCKED;
      end else if (w_event || w_timeout) begin
        w_state_nx = w_adv_fail ? S_FAIL : S_SETTLE;
        w_baud_nx  = w_wrap ? (w_adv_fail ? 3'd0 : 3'd7) : r_baud - 3'd1;
        w_pass_nx  = w_adv_pass;
        w_cnt_nx   = 32'd0;
        w_match_nx = 4'd0;
      end
    end
`ifdef AUTOBAUD_RELOCK_EN
    else if (r_state == S_LOCKED && w_event) begin
      w_err_nx = w_good ? 8'd0 : w_err_inc;
      if (!w_good && w_err_inc == 8'(ERR_LIMIT)) begin
        w_state_nx = S_SETTLE;
        w_baud_nx  = 3'd7;
        w_pass_nx  = 4'd0;
        w_cnt_nx   = 32'd0;
        w_err_nx   = 8'd0;
      end
    end
`endif
  end
  // state and search counters register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= 3'd7;
      r_pass  <= 4'd0;
      r_cnt   <= 32'd0;
      r_match <= 4'd0;
`ifdef AUTOBAUD_RELOCK_EN
      r_err   <= 8'd0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_baud  <= w_baud_nx;
      r_pass  <= w_pass_nx;
      r_cnt   <= w_cnt_nx;
      r_match <= w_match_nx;
`ifdef AUTOBAUD_RELOCK_EN
      r_err   <= w_err_nx;
`endif
    end
  end
  // receiver flag history for edge detection and forwarded byte register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_any_q <= 1'b0;
      r_dv    <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      r_any_q <= w_any;
      r_dv    <= w_fwd;
      if (w_fwd) r_data <= Rx_DATA;
    end
  end
endmodule

// File: tb/tb_uart_rx_autobaud_ctrl.sv
// tb_uart_rx_autobaud_ctrl: randomized directed checks of the autobaud controller against a candidate-level search model
module tb_uart_rx_autobaud_ctrl;
  localparam int TO = 100, SC = 4, MC = 2, MP = 2, EL = 3;
  logic       clk = 1'b0;
  logic       reset, start, abort, Rx_VALID, Rx_FERROR, Rx_PERROR;
  logic [7:0] Rx_DATA, data_out;
  logic [2:0] baud_select;
  logic       Rx_EN, busy, locked, fail, data_valid;
  logic [7:0] outs;
  logic [7:0] m_data;
  int         m_streak;
  int         n_cmp = 0, n_bad = 0;
  assign outs = {baud_select, Rx_EN, busy, locked, fail, data_valid};
  always #5 clk = ~clk;
  uart_rx_autobaud_ctrl #(
    .SYNC_BYTE(8'h55), .MATCH_COUNT(MC), .TIMEOUT(TO),
    .SETTLE_CYC(SC), .MAX_PASSES(MP), .ERR_LIMIT(EL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID), .Rx_FERROR(Rx_FERROR), .Rx_PERROR(Rx_PERROR),
    .baud_select(baud_select), .Rx_EN(Rx_EN), .busy(busy), .locked(locked), .fail(fail),
    .data_out(data_out), .data_valid(data_valid)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic fe, input logic pe, input logic [7:0] d);
    Rx_VALID  = v;
    Rx_FERROR = fe;
    Rx_PERROR = pe;
    Rx_DATA   = d;
  endtask

  task automatic drv_bad;
    logic [1:0] r;
    r = 2'($urandom_range(0, 3));
    drv(r[1], ~r[0], r[0], 8'($urandom));
  endtask

  task automatic do_start;
    start = 1'b1;
    drv(1'b0, 1'b0, 1'b0, 8'h00);
    tick;
    start = 1'b0;
  endtask

  // one baud candidate: SC quiet cycles then a listen window whose length follows from its plan
  // kinds: 0 silent, 1 bad frame, 2 wrong byte, 3 single sync, 4 sync then bad, 5 two syncs (lock)
  task automatic candidate(input int c, input int kind);
    logic [2:0] b;
    logic [7:0] w;
    int off, off2, len;
    b    = 3'(7 - c % 8);
    off  = $urandom_range(0, TO - 3);
    off2 = $urandom_range(off + 2, TO - 1);
    if ($urandom_range(0, 3) == 0) off2 = TO - 1;
    len  = (kind == 0 || kind == 3) ? TO : (kind >= 4) ? off2 + 1 : off + 1;
    w    = 8'($urandom);
    if (w == 8'h55) w = 8'h54;
    for (int i = 0; i < SC; i++) begin
      chk("settle", outs, {b, 5'b01000});
      start = (i == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (i == 1 && $urandom_range(0, 1) == 1) drv(1'b1, 1'b0, 1'b0, 8'h55);
      else drv(1'b0, 1'b0, 1'b0, 8'h00);
      tick;
    end
    for (int k = 0; k < len; k++) begin
      chk("listen", outs, {b, 5'b11000});
      if (k == off && kind != 0) begin
        if (kind == 1) drv_bad();
        else if (kind == 2) drv(1'b1, 1'b0, 1'b0, w);
        else drv(1'b1, 1'b0, 1'b0, 8'h55);
      end else if (k == off2 && kind == 4) drv_bad();
      else if (k == off2 && kind == 5) drv(1'b1, 1'b0, 1'b0, 8'h55);
      else drv(1'b0, 1'b0, 1'b0, 8'($urandom));
      tick;
    end
  endtask

  // whole search from candidate 'first'; lock_at < 0 means the line never qualifies
  task automatic search(input int first, input int lock_at, input int fk, output logic [2:0] lb);
    lb = 3'd0;
    for (int c = first; c < MP * 8; c++) begin
      if (c == lock_at) begin
        candidate(c, 5);
        lb = 3'(7 - c % 8);
        chk("lock", outs, {lb, 5'b10100});
        drv(1'b0, 1'b0, 1'b0, 8'h00);
        tick;
        chk("lock_hold", outs, {lb, 5'b10100});
        m_streak = 0;
        return;
      end
      candidate(c, (fk < 0) ? int'($urandom_range(0, 4)) : fk);
    end
    chk("fail", outs, {3'd0, 5'b00010});
  endtask

  // one frame while locked: kind 0 good, 1 random bad, 2 parity error
  task automatic lk_event(input int kind, input logic [7:0] d, input logic [2:0] lb, output bit rl);
    rl = 1'b0;
    if (kind == 0) drv(1'b1, 1'b0, 1'b0, d);
    else if (kind == 2) drv(1'b0, 1'b0, 1'b1, d);
    else drv_bad();
    tick;
    drv(1'b0, 1'b0, 1'b0, 8'h00);
    if (kind == 0) begin
      m_data = d;
      m_streak = 0;
    end else m_streak++;
`ifdef AUTOBAUD_RELOCK_EN
    if (m_streak == EL) begin
      chk("relock", outs, {3'd7, 5'b01000});
      m_streak = 0;
      rl = 1'b1;
      return;
    end
`endif
    chk("fwd", outs, {lb, 4'b1010, kind == 0});
    chk("fwd_data", data_out, m_data);
    tick;
    chk("fwd_gap", outs, {lb, 5'b10100});
  endtask

  initial begin
    logic [2:0] lb;
    bit rl;
    m_data = 8'h00;
    m_streak = 0;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    drv(1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) tick;
    chk("reset", outs, {3'd7, 5'b00000});
    chk("reset_dout", data_out, 8'h00);
    reset = 1'b0;
    tick;
    chk("idle", outs, {3'd7, 5'b00000});
    do_start;
    search(0, 2, 0, lb);
    chk("lock_baud5", baud_select, 3'd5);
    lk_event(0, 8'hA3, lb, rl);
    chk("dout_a3", data_out, 8'hA3);
    for (int j = 0; j < EL; j++) lk_event(2, 8'h55, lb, rl);
`ifdef AUTOBAUD_RELOCK_EN
    chk("relock_flag", rl, 1'b1);
    search(0, int'($urandom_range(0, 15)), -1, lb);
`else
    chk("no_relock", outs, {3'd5, 5'b10100});
`endif
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_locked", outs, {lb, 5'b00000});
    do_start;
    search(0, 1, 4, lb);
    for (int r = 0; r < 4; r++) begin
      do_start;
      search(0, int'($urandom_range(0, 15)), -1, lb);
      for (int j = 0; j < 15; j++) begin
        lk_event(($urandom_range(0, 2) == 0) ? 1 : 0, 8'($urandom), lb, rl);
        if (rl) search(0, int'($urandom_range(0, 7)), -1, lb);
      end
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    m_data = 8'h00;
    chk("reset_locked", outs, {3'd7, 5'b00000});
    chk("reset_locked_dout", data_out, 8'h00);
    do_start;
    search(0, -1, -1, lb);
    tick;
    chk("fail_hold", outs, {3'd0, 5'b00010});
    do_start;
    search(0, int'($urandom_range(0, 15)), -1, lb);
    do_start;
    repeat (SC + 5) tick;
    chk("pre_abort", outs, {3'd7, 5'b11000});
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_listen", outs, {3'd7, 5'b00000});
    tick;
    chk("abort_stay", outs, {3'd7, 5'b00000});
    start = 1'b1;
    abort = 1'b1;
    tick;
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort", outs, {3'd7, 5'b00000});
    tick;
    chk("start_abort_stay", outs, {3'd7, 5'b00000});
    do_start;
    repeat (SC + 3) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("reset_listen", outs, {3'd7, 5'b00000});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
